// File: rtl/ife_thresh_sequencer.sv
// rtl/ife_thresh_sequencer.sv - frame sequencer for the IFE threshold path
// Raster-scans the source image, optionally averaging it first, then writes f(pixel) in address order.
module ife_thresh_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int FIX_TH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [1:0]        sel,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic [ADDR_W-1:0] addr,
  output logic              wen,
  output logic [DATA_W-1:0] data_wr
);

  localparam int SUM_W = ADDR_W + DATA_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_PIX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [CNT_W-1:0]  LAST_WR  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0] FIX_TH_V = DATA_W'(FIX_TH);
  localparam logic [1:0]        SEL_MEAN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_DRAIN,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              wr_active;
  logic [DATA_W-1:0] pix_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      iaddr_q  <= '0;
      addr_q   <= '0;
      sum_q    <= '0;
      thresh_q <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iaddr_q  <= iaddr_d;
      addr_q   <= addr_d;
      sum_q    <= sum_d;
      thresh_q <= thresh_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iaddr_d  = iaddr_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    thresh_d = thresh_q;
    sel_d    = sel_q;
    busy_d   = busy_q;

    case (state_q)
      // DONE accepts a held ready directly so back-to-back frames see a single busy-low cycle.
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (ready) begin
          sel_d   = sel;
          busy_d  = 1'b1;
          cnt_d   = '0;
          iaddr_d = '0;
          sum_d   = '0;
          state_d = (sel == SEL_MEAN) ? S_SUM : S_WRITE;
        end
      end

      // idata lags iaddr by one cycle, so the first SUM cycle has nothing valid to add.
      S_SUM: begin
        if (cnt_q != '0) begin
          sum_d = sum_q + {{ADDR_W{1'b0}}, idata};
        end
        if (cnt_q == LAST_PIX) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          iaddr_d = iaddr_q + ADDR_W'(1);
        end
      end

      S_DRAIN: begin
        sum_d   = sum_q + {{ADDR_W{1'b0}}, idata};
        state_d = S_CALC;
      end

      S_CALC: begin
        thresh_d = sum_q[SUM_W-1 -: DATA_W];
        iaddr_d  = '0;
        cnt_d    = '0;
        state_d  = S_WRITE;
      end

      // addr trails iaddr by one cycle to line up with the returning idata.
      S_WRITE: begin
        addr_d = iaddr_q;
        if (cnt_q == LAST_WR) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q < LAST_PIX) begin
            iaddr_d = iaddr_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pix_out = idata;
    case (sel_q)
      2'd0:    pix_out = idata;
      2'd1:    pix_out = ~idata;
      2'd2:    pix_out = (idata >= FIX_TH_V) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      default: pix_out = (idata >= thresh_q) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    endcase
  end

  assign wr_active = (state_q == S_WRITE) && (cnt_q != '0);

  assign busy    = busy_q;
  assign iaddr   = iaddr_q;
  assign addr    = addr_q;
  assign wen     = wr_active;
  assign data_wr = wr_active ? pix_out : '0;

endmodule

// File: tb/tb_ife_thresh_sequencer.sv
// tb/tb_ife_thresh_sequencer.sv - self-checking bench for ife_thresh_sequencer
// Reduced frame (ADDR_W=12) keeps every scenario short; expectations come from a frame-level model.
module tb_ife_thresh_sequencer;

  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int N      = 1 << AW;
  localparam int TH_FIX = 128;

  logic          clk;
  logic          reset;
  logic          ready;
  logic [1:0]    sel;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW-1:0] data_wr;

  ife_thresh_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIX_TH(TH_FIX)) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .sel     (sel),
    .busy    (busy),
    .iaddr   (iaddr),
    .idata   (idata),
    .addr    (addr),
    .wen     (wen),
    .data_wr (data_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [N];
  logic [7:0] res [N];

  always @(posedge clk) idata <= mem[iaddr];

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_len_q[$];
  int  n_chk    = 0;
  int  n_fail   = 0;
  int  run      = 0;
  int  low_run  = 0;
  int  last_len = 0;
  int  last_gap = 0;
  int  wr_total = 0;
  int  model_th = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int f_model(input int p, input int s, input int th);
    case (s)
      0:       return p;
      1:       return 255 - p;
      2:       return (p >= TH_FIX) ? 255 : 0;
      default: return (p >= th) ? 255 : 0;
    endcase
  endfunction

  task automatic plan_frame(input int s);
    longint total;
    int th;
    wr_t w;
    total = 0;
    th = 0;
    if (s == 3) begin
      for (int i = 0; i < N; i++) total += longint'(mem[i]);
      th = int'(total / N);
    end
    model_th = th;
    for (int i = 0; i < N; i++) begin
      w.a = i;
      w.d = f_model(int'(mem[i]), s, th);
      exp_q.push_back(w);
    end
    exp_len_q.push_back((s == 3) ? 2 * N + 3 : N + 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_wen", wen, 0);
      chk("rst_iaddr", iaddr, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data_wr", data_wr, 0);
      exp_q.delete();
      exp_len_q.delete();
      run     = 0;
      low_run = 0;
    end else begin
      if (wen) begin
        wr_total++;
        chk("wen_implies_busy", busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_data", data_wr, e.d);
        end
        res[addr] = data_wr;
      end
      if (busy) begin
        if (run == 0) last_gap = low_run;
        run++;
        low_run = 0;
      end else begin
        if (run > 0) begin
          last_len = run;
          if (exp_len_q.size() == 0) chk("unexpected_frame", 1, 0);
          else chk("busy_len", run, exp_len_q.pop_front());
          run = 0;
        end
        low_run++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < 2 * N + 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, lvl);
  endtask

  task automatic start_frame(input int s);
    sel   = 2'(s);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  initial begin
    int snap;
    reset = 1'b1;
    ready = 1'b0;
    sel   = 2'd0;
    for (int i = 0; i < N; i++) begin
      mem[i] = 8'h40;
      res[i] = 8'h55;
    end
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);
    chk("idle_wen", wen, 0);

    // flat image, mean threshold
    plan_frame(3);
    chk("model_th_flat", model_th, 8'h40);
    start_frame(3);
    chk("t1_busy_rise", busy, 1);
    wait_busy(1'b0, "t1_end_timeout");
    step(1);
    chk("t1_len", last_len, 8195);
    chk("t1_pending", exp_q.size(), 0);
    chk("t1_res0", res[0], 255);
    chk("t1_res_last", res[N-1], 255);

    // ramp, mean threshold, sel flipped to copy mid-SUM
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    plan_frame(3);
    chk("model_th_ramp", model_th, 8'h7F);
    start_frame(3);
    step(100);
    sel = 2'd0;
    wait_busy(1'b0, "t2_end_timeout");
    step(1);
    chk("t2_len", last_len, 8195);
    chk("t2_pending", exp_q.size(), 0);
    chk("t2_res126", res[126], 0);
    chk("t2_res127", res[127], 255);
    chk("t2_res255", res[255], 255);
    chk("t2_res256", res[256], 0);

    // copy then invert, ready held across DONE
    plan_frame(0);
    plan_frame(1);
    sel   = 2'd0;
    ready = 1'b1;
    step(1);
    sel = 2'd1;
    chk("t3_busy_rise", busy, 1);
    wait_busy(1'b0, "t3a_end_timeout");
    wait_busy(1'b1, "t3b_start_timeout");
    ready = 1'b0;
    wait_busy(1'b0, "t3b_end_timeout");
    step(1);
    chk("t3_gap", last_gap, 1);
    chk("t3_len", last_len, 4097);
    chk("t3_pending", exp_q.size(), 0);
    chk("t3_res5", res[5], 250);
    chk("t3_res300", res[300], 211);

    // reset in the middle of a fixed-threshold write pass
    plan_frame(2);
    snap = wr_total;
    start_frame(2);
    step(3001);
    chk("t4_pre_wen", wen, 1);
    chk("t4_pre_addr", addr, 3000);
    reset = 1'b0;
    #1;
    chk("t4_async_busy", busy, 0);
    chk("t4_async_wen", wen, 0);
    chk("t4_async_data", data_wr, 0);
    chk("t4_async_addr", addr, 0);
    chk("t4_async_iaddr", iaddr, 0);
    chk("t4_writes_before", wr_total - snap, 3000);
    snap = wr_total;
    step(3);
    reset = 1'b1;
    step(10);
    chk("t4_writes_after", wr_total - snap, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_res127", res[127], 0);
    chk("t4_res128", res[128], 255);
    chk("t4_res3000", res[3000], 71);

    // next frame after the abandoned one
    for (int i = 0; i < N; i++) mem[i] = 8'((i * 37 + 11) & 255);
    plan_frame(2);
    start_frame(2);
    wait_busy(1'b0, "t5_end_timeout");
    step(1);
    chk("t5_len", last_len, 4097);
    chk("t5_pending", exp_q.size(), 0);
    chk("t5_res0", res[0], 0);
    chk("t5_res3", res[3], 0);
    chk("t5_res4", res[4], 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
